// File: rtl/shift_sequencer_pkg.sv
// Shared constants and types for the iterative shift sequencer.
// State encodings are fixed values so older tools and dumps decode them unchanged.
package shift_sequencer_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  typedef struct packed {
    logic lr;
    logic la;
  } mode_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-position 8-bit shift stage: left (zero fill) or right (logical/arithmetic).
// Purely combinational; the sequencer steps it once per clock.
module shifter
  import shift_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic             lr,
  input  logic             la,
  output logic [WIDTH-1:0] y,
  output logic             c
);

  always_comb begin
    if (lr) begin
      y = {(la & a[WIDTH-1]), a[WIDTH-1:1]};
      c = a[0];
    end else begin
      y = {a[WIDTH-2:0], 1'b0};
      c = a[WIDTH-1];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shifter: runs the single-position stage once per clock for 0-7 places,
// with a START/BUSY/DONE handshake toward the datapath controller.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [CNT_W-1:0] n,
  input  logic             lr,
  input  logic             la,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             c
  ,output logic            z
);

  logic [1:0]       state;
  logic [WIDTH-1:0] r;
  logic [CNT_W-1:0] cnt;
  mode_t            mode;
  logic             c_reg;
  logic [WIDTH-1:0] sh_y;
  logic             sh_c;

  shifter u_shifter (
    .a  (r),
    .lr (mode.lr),
    .la (mode.la),
    .y  (sh_y),
    .c  (sh_c)
  );

  // START is only honoured in IDLE, so a request during SHIFT or DONE leaves the
  // operand, count and mode untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      r     <= '0;
      cnt   <= '0;
      mode  <= '0;
      c_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            r     <= a;
            cnt   <= n;
            mode  <= '{lr: lr, la: la};
            c_reg <= 1'b0;
            state <= (n == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r     <= sh_y;
          c_reg <= sh_c;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_SHIFT) || (state == ST_DONE);
  assign done = (state == ST_DONE);
  assign y    = r;
  assign c    = c_reg;
  assign z    = (r == '0);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, hand-written
// corner sequences and randomized operations checked against an arithmetic model.
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [2:0] n;
  logic       lr;
  logic       la;
  logic       busy;
  logic       done;
  logic [7:0] y;
  logic       c;
  logic       z;

  int compared;
  int mismatched;

  shift_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .n     (n),
    .lr    (lr),
    .la    (la),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .c     (c),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [2:0] n;
    logic       lr;
    logic       la;
    logic [7:0] exp_y;
    logic       exp_c;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: whole shift computed in one step from the operand and count.
  task automatic model(input logic [7:0] a_v, input int n_v, input logic lr_v, input logic la_v,
                       output logic [7:0] y_exp, output logic c_exp);
    logic [15:0]       wide;
    logic signed [7:0] sa;
    if (n_v == 0) begin
      y_exp = a_v;
      c_exp = 1'b0;
    end else if (!lr_v) begin
      wide  = {8'h00, a_v} << n_v;
      y_exp = wide[7:0];
      c_exp = a_v[8 - n_v];
    end else if (la_v) begin
      sa    = a_v;
      y_exp = sa >>> n_v;
      c_exp = a_v[n_v - 1];
    end else begin
      y_exp = a_v >> n_v;
      c_exp = a_v[n_v - 1];
    end
  endtask

  // Called #1 after a rising edge in IDLE; returns in the cycle DONE is seen (or on timeout).
  task automatic applyStimulus(input logic [7:0] a_v, input logic [2:0] n_v, input logic lr_v,
                               input logic la_v, output int lat, output int busy_bad);
    a = a_v; n = n_v; lr = lr_v; la = la_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; n = $urandom; lr = $urandom; la = $urandom;
    lat = 0;
    busy_bad = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [7:0] a_v, input logic [2:0] n_v,
                             input logic lr_v, input logic la_v);
    int         lat;
    int         busy_bad;
    logic [7:0] y_exp;
    logic       c_exp;
    model(a_v, int'(n_v), lr_v, la_v, y_exp, c_exp);
    applyStimulus(a_v, n_v, lr_v, la_v, lat, busy_bad);
    checkOutput({tag, " latency"}, lat, (n_v == 0) ? 1 : int'(n_v) + 1);
    checkOutput({tag, " busy"}, busy_bad, 0);
    checkOutput({tag, " y"}, {24'h0, y}, {24'h0, y_exp});
    checkOutput({tag, " c"}, {31'h0, c}, {31'h0, c_exp});
    checkOutput({tag, " z"}, {31'h0, z}, {31'h0, (y_exp == 8'h00)});
    @(posedge clk); #1;
    checkOutput({tag, " idle busy"}, {31'h0, busy}, 0);
    checkOutput({tag, " idle done"}, {31'h0, done}, 0);
    checkOutput({tag, " hold y"}, {24'h0, y}, {24'h0, y_exp});
    checkOutput({tag, " hold c"}, {31'h0, c}, {31'h0, c_exp});
  endtask

  vec_t vecs[8];

  initial begin
    int done_cnt;
    int lat;
    compared   = 0;
    mismatched = 0;
    rst = 1'b1; start = 1'b0; a = '0; n = '0; lr = 1'b0; la = 1'b0;

    vecs[0] = '{8'h81, 3'd1, 1'b0, 1'b0, 8'h02, 1'b1};
    vecs[1] = '{8'h80, 3'd3, 1'b1, 1'b1, 8'hF0, 1'b0};
    vecs[2] = '{8'h80, 3'd3, 1'b1, 1'b0, 8'h10, 1'b0};
    vecs[3] = '{8'hB5, 3'd0, 1'b0, 1'b0, 8'hB5, 1'b0};
    vecs[4] = '{8'h40, 3'd7, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h01, 3'd7, 1'b0, 1'b0, 8'h80, 1'b0};
    vecs[6] = '{8'hC3, 3'd2, 1'b1, 1'b1, 8'hF0, 1'b1};
    vecs[7] = '{8'h5A, 3'd5, 1'b0, 1'b1, 8'h40, 1'b1};

    #12;
    checkOutput("reset busy", {31'h0, busy}, 0);
    checkOutput("reset done", {31'h0, done}, 0);
    checkOutput("reset y", {24'h0, y}, 0);
    checkOutput("reset z", {31'h0, z}, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      string tag;
      int    lat_v;
      int    busy_bad;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].a, vecs[i].n, vecs[i].lr, vecs[i].la, lat_v, busy_bad);
      checkOutput({tag, " latency"}, lat_v, (vecs[i].n == 0) ? 1 : int'(vecs[i].n) + 1);
      checkOutput({tag, " busy"}, busy_bad, 0);
      checkOutput({tag, " y"}, {24'h0, y}, {24'h0, vecs[i].exp_y});
      checkOutput({tag, " c"}, {31'h0, c}, {31'h0, vecs[i].exp_c});
      checkOutput({tag, " z"}, {31'h0, z}, {31'h0, (vecs[i].exp_y == 8'h00)});
      @(posedge clk); #1;
      checkOutput({tag, " idle busy"}, {31'h0, busy}, 0);
      checkOutput({tag, " idle done"}, {31'h0, done}, 0);
    end

    // START pulsed mid-shift and held through DONE must be ignored.
    a = 8'h0F; n = 3'd4; lr = 1'b0; la = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 8'hFF; n = 3'd1; lr = 1'b1; start = 1'b1;
    done_cnt = 0;
    lat = 0;
    for (int i = 2; i <= 20; i++) begin
      if (done === 1'b1) begin
        done_cnt++;
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("ignore latency", lat, 5);
    checkOutput("ignore y", {24'h0, y}, 32'hF0);
    checkOutput("ignore c", {31'h0, c}, 0);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    checkOutput("ignore single done", done_cnt, 1);

    // Asynchronous reset after two shifts aborts the operation without DONE.
    a = 8'hFF; n = 3'd5; lr = 1'b0; la = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("abort pre y", {24'h0, y}, 32'hFC);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort y", {24'h0, y}, 0);
    checkOutput("abort c", {31'h0, c}, 0);
    checkOutput("abort busy", {31'h0, busy}, 0);
    checkOutput("abort z", {31'h0, z}, 1);
    checkOutput("abort done", {31'h0, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    checkOutput("abort no done", done_cnt, 0);
    runAndCheck("after abort", 8'h03, 3'd1, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      runAndCheck($sformatf("rand%0d", i), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-bit shift engine that runs the existing 8-bit single-position `shifter` stage iteratively, one position per clock, to shift an operand by 0–7 places. It sits directly upstream of `shifter`: it supplies `shifter`'s operand and mode inputs and registers `shifter`'s result and carry back every cycle. A START/BUSY/DONE handshake connects it to the datapath controller. It returns the final 8-bit value, the last bit shifted out and a zero flag.

## Interface
- Parameters: none. Width is fixed at 8 by the `shifter` stage.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request. Sampled only in IDLE.
- A  in  8  operand. Captured with an accepted START.
- N  in  3  shift count, 0–7. Captured with an accepted START.
- LR  in  1  direction: 1 = right, 0 = left. Captured with an accepted START.
- LA  in  1  right-shift fill: 1 = arithmetic (replicate bit 7), 0 = logical (fill 0). Ignored for left shifts. Captured with an accepted START.
- BUSY  out  1  high in SHIFT and DONE states.
- DONE  out  1  one-cycle pulse; result valid.
- Y  out  8  result register.
- C  out  1  last bit shifted out.
- Z  out  1  combinational, equals (Y == 8'h00).

## Operation
- State machine: IDLE, SHIFT, DONE.
- IDLE, START=1 (accepted):
  - R ← A, cnt ← N, mode ← {LR, LA}, C ← 0.
  - Next state: DONE if N == 0, else SHIFT.
- SHIFT, every cycle:
  - R ← shifter.Y(R, mode).
  - C ← shifter.C(R, mode).
  - cnt ← cnt − 1.
  - When cnt == 1 at this edge, next state is DONE; otherwise stay in SHIFT.
- DONE: DONE = 1 for exactly one cycle, then IDLE unconditionally.
- Y drives R directly. Y is meaningful only in DONE and in the following IDLE. Y and C hold until the next accepted START.
- Shift semantics, per step:
  - Left: zero-fill at bit 0; C = old bit 7.
  - Right logical: zero-fill at bit 7; C = old bit 0.
  - Right arithmetic: bit 7 retained; C = old bit 0.
- N == 0: result = A, C = 0.
- START while BUSY, including in DONE: ignored, with no effect on R, cnt or mode. The controller must re-assert START after DONE.
- Changes on A/N/LR/LA after acceptance have no effect.
- RST, at any time including mid-shift:
  - State = IDLE, R = 0, cnt = 0, mode = 0, C = 0.
  - Therefore BUSY = 0, DONE = 0, Y = 0, Z = 1.
  - The aborted operation produces no DONE pulse.

## Timing
- START sampled at edge k:
  - BUSY high from cycle k+1.
  - N shift edges follow.
  - DONE high in cycle k+N+1 (k+1 when N = 0).
  - BUSY low from cycle k+N+2.
- Earliest back-to-back acceptance: START at edge k+N+2. Throughput is one operation per N+2 cycles.
- No combinational path from inputs to outputs. Z is derived only from the Y register.
- The `shifter` instance is purely combinational between R and the R/C registers. There is one shifter delay per cycle.

## Structure
- Shared package/include:
  - State encoding: IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10. Encoding 2'b11 is illegal and returns to IDLE.
  - Width constant: 8.
  - Count-width constant: 3.
- Exactly one sub-module: `shifter`, instantiated once.
  - Its A input is driven by R and its LR/LA inputs by the mode register.
  - Its Y and C outputs feed the R and C registers.
- The sequencer does not re-implement any shift logic.

## Test plan
- A=8'h81, N=1, LR=0, START at edge k → DONE in cycle k+2, Y=8'h02, C=1, Z=0.
- A=8'h80, N=3, LR=1, LA=1 → Y=8'hF0, C=0. Repeat with LA=0 → Y=8'h10, C=0. DONE in cycle k+4 in both cases.
- A=8'hB5, N=0 → DONE in cycle k+1, Y=8'hB5, C=0. BUSY high for exactly 1 cycle.
- A=8'h40, N=7, LR=1, LA=0 → Y=8'h00, C=1, Z=1. Also A=8'h01, N=7, LR=0 → Y=8'h80, C=0.
- A=8'h0F, N=4, LR=0; during SHIFT, START pulsed with A=8'hFF → ignored; result Y=8'hF0, C=0, single DONE.
- A=8'hFF, N=5; RST asserted asynchronously after 2 shifts → Y=0, C=0, BUSY=0, Z=1 immediately, no DONE. Next START with A=8'h03, N=1, LR=1 → Y=8'h01, C=1.
